// File: rtl/serial_sub7bit_if.sv
// Operand/result handshake bundle for the bit-serial subtractor.
// The master side issues operands and consumes the difference; the slave side is the subtractor.
interface serial_sub7bit_if #(parameter int WIDTH = 7);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH:0]   diff;
  logic             out_valid;
  logic             out_ready;

  modport master (output in_valid, a, b, out_ready,
                  input  in_ready, diff, out_valid);
  modport slave  (input  in_valid, a, b, out_ready,
                  output in_ready, diff, out_valid);
endinterface

// File: rtl/serial_sub7bit.sv
// Bit-serial unsigned subtractor: one full-subtractor bit per clock, LSB first.
// diff = {borrow_out, (a-b) mod 2^WIDTH}, presented with a valid/ready handshake.
module serial_sub7bit #(
  parameter int WIDTH = 7
) (
  input  logic           clk,
  input  logic           rst_n,
  serial_sub7bit_if.slave bus
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_sr, b_sr, res_sr;
  logic             borrow;
  logic [CW-1:0]    cnt;
  logic [WIDTH:0]   diff_q;

  logic ai, bi, rbit, bnext, last;

  always_comb begin
    ai    = a_sr[0];
    bi    = b_sr[0];
    rbit  = ai ^ bi ^ borrow;
    bnext = (~ai & bi) | (~(ai ^ bi) & borrow);
    last  = (cnt == CW'(WIDTH - 1));
  end

  always_comb begin
    state_nxt     = state;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    case (state)
      IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) state_nxt = RUN;
      end
      RUN:  if (last) state_nxt = DONE;
      DONE: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      a_sr   <= '0;
      b_sr   <= '0;
      res_sr <= '0;
      borrow <= 1'b0;
      cnt    <= '0;
      diff_q <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: if (bus.in_valid) begin
          a_sr   <= bus.a;
          b_sr   <= bus.b;
          borrow <= 1'b0;
          cnt    <= '0;
        end
        RUN: begin
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          res_sr <= {rbit, res_sr[WIDTH-1:1]};
          borrow <= bnext;
          cnt    <= cnt + 1'b1;
          // Snapshot the finished word so diff stays put through DONE and the next RUN.
          if (last) diff_q <= {bnext, rbit, res_sr[WIDTH-1:1]};
        end
        default: ;
      endcase
    end
  end

  assign bus.diff = diff_q;

endmodule

// File: tb/tb_serial_sub7bit.sv
// Directed + randomized check of serial_sub7bit: results, 7-edge latency, backpressure, reset abort.
module tb_serial_sub7bit;

  logic clk = 1'b0;
  logic rst_n;
  int   n_cmp = 0;
  int   n_err = 0;

  serial_sub7bit_if #(.WIDTH(7)) bus ();

  serial_sub7bit #(.WIDTH(7)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issue one operation; noise scrambles a/b/in_valid/out_ready while the op is in flight.
  task automatic run_op(input string tag, input logic [6:0] av, input logic [6:0] bv,
                        input logic [7:0] exp, input int hold, input bit noise);
    int t;
    int lat;
    logic [7:0] held;
    t = 0;
    while (!bus.in_ready && t < 50) begin tick(); t++; end
    chk({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
    bus.a = av; bus.b = bv; bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    lat = 0;
    while (!bus.out_valid && lat < 20) begin
      if (noise) begin
        bus.a         = 7'($urandom);
        bus.b         = 7'($urandom);
        bus.in_valid  = 1'($urandom);
        bus.out_ready = 1'($urandom);
      end
      chk({tag, "_busy_in_ready"}, 32'(bus.in_ready), 32'd0);
      tick();
      lat++;
    end
    chk({tag, "_latency"}, 32'(lat), 32'd7);
    chk({tag, "_diff"}, 32'(bus.diff), 32'(exp));
    held = bus.diff;
    bus.out_ready = 1'b0;
    for (int i = 0; i < hold; i++) begin
      if (noise) begin
        bus.a = 7'($urandom); bus.b = 7'($urandom); bus.in_valid = 1'($urandom);
      end
      tick();
      chk({tag, "_hold_valid"}, 32'(bus.out_valid), 32'd1);
      chk({tag, "_hold_diff"}, 32'(bus.diff), 32'(held));
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    chk({tag, "_drop_valid"}, 32'(bus.out_valid), 32'd0);
    chk({tag, "_back_idle"}, 32'(bus.in_ready), 32'd1);
    chk({tag, "_keep_diff"}, 32'(bus.diff), 32'(exp));
  endtask

  initial begin
    logic [6:0] ra, rb, rd;
    logic [7:0] rexp;

    rst_n = 1'b0;
    bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.out_ready = 1'b0;
    tick(); tick();
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_in_ready",  32'(bus.in_ready),  32'd1);
    chk("rst_diff",      32'(bus.diff),      32'd0);
    rst_n = 1'b1;
    tick();

    run_op("5m3",     7'd5,   7'd3,   8'h02, 0, 1'b0);
    run_op("3m5",     7'd3,   7'd5,   8'hFE, 0, 1'b0);
    run_op("127m0",   7'd127, 7'd0,   8'h7F, 0, 1'b0);
    run_op("0m127",   7'd0,   7'd127, 8'h81, 0, 1'b0);
    run_op("0m0",     7'd0,   7'd0,   8'h00, 0, 1'b0);
    run_op("127m127", 7'd127, 7'd127, 8'h00, 0, 1'b0);
    run_op("bp_3m5",  7'd3,   7'd5,   8'hFE, 10, 1'b1);

    // Abort at bit 3 of 100-27; in_valid held high across the reset edge must not be accepted.
    bus.a = 7'd100; bus.b = 7'd27; bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    tick(); tick(); tick();
    rst_n = 1'b0; bus.in_valid = 1'b1;
    tick();
    rst_n = 1'b1; bus.in_valid = 1'b0;
    chk("abort_in_ready", 32'(bus.in_ready), 32'd1);
    chk("abort_diff",     32'(bus.diff),     32'd0);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("abort_no_valid", 32'(bus.out_valid), 32'd0);
    end
    run_op("100m27", 7'd100, 7'd27, 8'h49, 0, 1'b0);

    for (int i = 0; i < 1000; i++) begin
      ra = 7'($urandom);
      rb = 7'($urandom);
      rd = ra - rb;
      rexp = {(ra < rb), rd};
      for (int g = $urandom_range(0, 2); g > 0; g--) tick();
      run_op("rand", ra, rb, rexp, $urandom_range(0, 2), 1'b1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/serial_sub7bit.md
SERIAL_SUB7BIT -- requirements
Module: serial_sub7bit

Interface
REQ-001 The parameter list SHALL be: WIDTH, default 7, operand width in bits (all widths below follow WIDTH).
REQ-002 Port clk SHALL be: input, 1 bit, the single clock; all state updates on its rising edge.
REQ-003 Port rst_n SHALL be: input, 1 bit, reset, synchronous and active-low.
REQ-004 Port in_valid SHALL be: input, 1 bit, operands a/b present.
REQ-005 Port in_ready SHALL be: output, 1 bit, block can accept operands.
REQ-006 Port a SHALL be: input, WIDTH bits, minuend, unsigned.
REQ-007 Port b SHALL be: input, WIDTH bits, subtrahend, unsigned.
REQ-008 Port diff SHALL be: output, WIDTH+1 bits; diff[WIDTH-1:0] = (a-b) mod 2^WIDTH; diff[WIDTH] = borrow-out (1 iff a<b).
REQ-009 Port out_valid SHALL be: output, 1 bit, diff holds a finished result.
REQ-010 Port out_ready SHALL be: input, 1 bit, consumer accepts diff.

Function
REQ-011 The block SHALL compute a-b bit-serially, LSB first, one full-subtractor bit per clock, with a 1-bit borrow register.
REQ-012 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-013 In IDLE: in_ready=1 and out_valid=0.
REQ-014 In RUN and DONE: in_ready=0.
REQ-015 Acceptance SHALL occur on a rising edge with in_valid=1 and in_ready=1; at that edge a and b are latched into internal shift registers, borrow=0, bit counter=0, and state goes IDLE->RUN.
REQ-016 a and b SHALL be sampled only at the acceptance edge; later changes to them SHALL NOT affect the result.
REQ-017 In RUN, on each edge (with ai, bi = current LSBs of the shift registers, br = borrow): result bit = ai^bi^br; borrow <= (~ai&bi) | (~(ai^bi)&br); both operand registers shift right by 1; the result bit enters the MSB of the result shift register; the counter increments.
REQ-018 The counter SHALL be wide enough to count WIDTH (3 bits at WIDTH=7).
REQ-019 RUN->DONE SHALL occur on the edge that processes bit WIDTH-1 (the counter reaching WIDTH-1).
REQ-020 out_valid SHALL rise exactly WIDTH clock edges after the acceptance edge (7 at default).
REQ-021 In DONE: out_valid=1 and diff={borrow, result register}.
REQ-022 diff SHALL remain stable while out_valid=1.
REQ-023 DONE->IDLE SHALL occur on an edge with out_ready=1; out_valid falls on that edge.
REQ-024 With out_ready=0 the block SHALL hold DONE and diff indefinitely (backpressure).
REQ-025 in_valid SHALL be ignored in RUN and DONE; no operand is queued or lost-tracked.
REQ-026 A new acceptance SHALL occur no earlier than the first IDLE cycle after DONE, giving a minimum issue interval of WIDTH+2 cycles.
REQ-027 out_ready asserted outside DONE SHALL have no effect.
REQ-028 diff SHALL retain its last completed value in IDLE and RUN, but it is qualified only by out_valid.
REQ-029 Arithmetic SHALL be modulo 2^WIDTH, with no saturation; borrow-out is the sole sign/underflow indicator.

Reset
REQ-030 On a rising edge with rst_n=0, the block SHALL set: state=IDLE, in_ready=1, out_valid=0, diff=0, borrow=0, counter=0, all shift registers=0.
REQ-031 Reset asserted during RUN or DONE SHALL abort the operation with no result delivered; the first edge with rst_n=1 may accept new operands.
REQ-032 Reset SHALL take priority over every other input in the same cycle.

Verification
REQ-033 Test: a=5, b=3 accepted -> 7 cycles later out_valid=1, diff=8'h02.
REQ-034 Test: a=3, b=5 -> diff=8'hFE (borrow 1, low bits 7'h7E).
REQ-035 Test: corner operands: a=127, b=0 -> diff=8'h7F; a=0, b=127 -> diff=8'h81; a=b=0 -> diff=8'h00; a=b=127 -> diff=8'h00.
REQ-036 Test: out_ready held 0 for 10 cycles after completion -> out_valid and diff stable throughout; a/b and in_valid toggled during RUN/DONE have no effect; in_ready returns 1 the cycle after out_ready handshake.
REQ-037 Test: rst_n=0 for one cycle at bit 3 of a=100, b=27 -> out_valid stays 0, diff=0; a following operation a=100, b=27 -> diff=8'h49.
REQ-038 Test: random sweep of ≥1000 operand pairs with random in_valid/out_ready gaps -> every diff equals {a<b, (a-b) mod 128}, and latency is 7 edges from acceptance to out_valid.
